// File: rtl/fir_stream_ctrl.sv
// Sequencing controller for the 8-in/16-out FIR core. It feeds one sample at a time,
// waits out the core latency, buffers results in a FIFO and streams them as byte pairs.
module fir_stream_ctrl #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [7:0]  in_dat,
    output logic [7:0]  core_x,
    input  logic [15:0] core_y,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [7:0]  out_byte,
    output logic        out_hi,
    output logic        busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [3:0]    LAT_M1  = 4'(LAT - 1);

    typedef enum logic {
        ACC_IDLE,
        ACC_WAIT
    } acc_state_t;

    typedef enum logic [1:0] {
        SER_EMPTY,
        SER_LO,
        SER_HI
    } ser_state_t;

    acc_state_t    acc_state_q, acc_state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [7:0]    core_x_q, core_x_d;
    ser_state_t    ser_state_q, ser_state_d;
    logic [15:0]   hold_q, hold_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   fifo_count_q, fifo_count_d;
    logic [15:0]   fifo_mem [DEPTH];
    logic          push;
    logic          pop;
    logic          fifo_empty;

    assign fifo_empty = (fifo_count_q == '0);

    // Gating with rst keeps in_rdy low for the whole reset window, yet high right after it.
    assign in_rdy = !rst && (acc_state_q == ACC_IDLE) && (fifo_count_q < DEPTH_C);

    always_comb begin
        acc_state_d = acc_state_q;
        wait_cnt_d  = wait_cnt_q;
        core_x_d    = core_x_q;
        push        = 1'b0;
        case (acc_state_q)
            ACC_IDLE: begin
                if (in_vld && in_rdy) begin
                    core_x_d    = in_dat;
                    wait_cnt_d  = LAT_M1;
                    acc_state_d = ACC_WAIT;
                end
            end
            ACC_WAIT: begin
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    push        = 1'b1;
                    acc_state_d = ACC_IDLE;
                end
            end
            default: acc_state_d = ACC_IDLE;
        endcase
    end

    always_comb begin
        ser_state_d = ser_state_q;
        hold_d      = hold_q;
        pop         = 1'b0;
        case (ser_state_q)
            SER_EMPTY: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    hold_d      = fifo_mem[rd_ptr_q];
                    ser_state_d = SER_LO;
                end
            end
            SER_LO: begin
                if (out_rdy) begin
                    ser_state_d = SER_HI;
                end
            end
            SER_HI: begin
                if (out_rdy) begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        hold_d      = fifo_mem[rd_ptr_q];
                        ser_state_d = SER_LO;
                    end else begin
                        ser_state_d = SER_EMPTY;
                    end
                end
            end
            default: ser_state_d = SER_EMPTY;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d     = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d     = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        fifo_count_d = fifo_count_q;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_ONE;
            2'b01:   fifo_count_d = fifo_count_q - CNT_ONE;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_state_q  <= ACC_IDLE;
            wait_cnt_q   <= 4'd0;
            core_x_q     <= 8'd0;
            ser_state_q  <= SER_EMPTY;
            hold_q       <= 16'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            acc_state_q  <= acc_state_d;
            wait_cnt_q   <= wait_cnt_d;
            core_x_q     <= core_x_d;
            ser_state_q  <= ser_state_d;
            hold_q       <= hold_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // Storage needs no reset; the pointer reset discards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= core_y;
        end
    end

    assign core_x   = core_x_q;
    assign out_vld  = (ser_state_q != SER_EMPTY);
    assign out_hi   = (ser_state_q == SER_HI);
    assign out_byte = (ser_state_q == SER_HI) ? hold_q[15:8] :
                      (ser_state_q == SER_LO) ? hold_q[7:0]  : 8'd0;
    assign busy     = (acc_state_q == ACC_WAIT) || !fifo_empty || (ser_state_q != SER_EMPTY);

endmodule

// File: doc/fir_stream_ctrl.md
# fir_stream_ctrl

Sequencing controller for the 8-in/16-out FIR core. It accepts input samples over a valid/ready handshake and presents each sample to the core. It then waits the core's fixed latency, captures the 16-bit result into a small FIFO, and streams each result out as two bytes (low then high) so the result fits the 8-bit pin budget. It sits between the top-level pin wrapper and the FIR core and replaces direct pin-to-core wiring.

## Interface
Parameters:
- `LAT`, default 3: core latency in cycles from a `core_x` change to a valid `core_y`. Legal range is 1..15.
- `DEPTH`, default 4: result FIFO depth in 16-bit entries. Must be a power of two, 2..16.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_vld`  in  1  input sample valid.
- `in_rdy`  out  1  controller can accept a sample.
- `in_dat`  in  8  input sample.
- `core_x`  out  8  registered sample driven to the FIR core.
- `core_y`  in  16  FIR core result.
- `out_vld`  out  1  output byte valid.
- `out_rdy`  in  1  downstream accepts the byte.
- `out_byte`  out  8  output byte.
- `out_hi`  out  1  0 = low byte of result, 1 = high byte.
- `busy`  out  1  a sample is in flight, or the FIFO or serializer holds data.

## Operation
- Accept FSM states:
  - IDLE:
    - `in_rdy` = (fifo_count < DEPTH).
    - On `in_vld && in_rdy`: `core_x` <= `in_dat`, wait_cnt <= LAT-1, go to WAIT.
  - WAIT:
    - `in_rdy` = 0.
    - If wait_cnt != 0: decrement.
    - If wait_cnt == 0: push `core_y` into the FIFO, go to IDLE.
- At most one sample is in flight.
  - The FIFO is checked for space at acceptance, and nothing else pushes while the sample is in flight.
  - A push into a full FIFO is therefore impossible; assert this in the bench.
- `core_x` holds its value between acceptances.
- Serializer states:
  - EMPTY: if FIFO non-empty, pop the head into a 16-bit holding register, go to LO.
  - LO: `out_vld` = 1, `out_hi` = 0, `out_byte` = hold[7:0]. On `out_rdy`, go to HI.
  - HI: `out_vld` = 1, `out_hi` = 1, `out_byte` = hold[15:8]. On `out_rdy`:
    - If FIFO non-empty: pop into hold, go to LO (back-to-back).
    - Otherwise: go to EMPTY.
- There is no bypass: a push into an empty FIFO is visible to the serializer on the next cycle.
- Simultaneous push and pop in one cycle is legal: fifo_count is unchanged and pointers wrap modulo DEPTH.
- `out_byte` holds stable while `out_vld && !out_rdy`.
- `busy` = (state == WAIT) || fifo_count != 0 || serializer != EMPTY.
- Reset mid-operation:
  - Any in-flight sample, all FIFO contents and any partial byte pair are discarded.
  - No stale byte may appear after reset.

## Timing
- Reset values, held while `rst` = 1:
  - FSM = IDLE, serializer = EMPTY, fifo_count = 0, pointers = 0.
  - `core_x` = 0, `in_rdy` = 0, `out_vld` = 0, `out_byte` = 0, `out_hi` = 0, `busy` = 0.
- `in_rdy` is 1 in the first cycle after `rst` deasserts.
- For a sample accepted at edge t:
  - `core_x` changes after edge t.
  - `core_y` is sampled at edge t+LAT.
  - The earliest next acceptance is edge t+LAT+1.
  - Peak input rate is one sample per LAT+1 cycles.
- With the FIFO and serializer empty:
  - Serializer pops at edge t+LAT+1 and `out_vld` rises after it.
  - With `out_rdy` = 1: low byte transfers at edge t+LAT+2, high byte at t+LAT+3.
- The serializer needs 2 cycles per result. Since LAT ≥ 1, a continuously ready sink never causes FIFO growth.
- Under backpressure:
  - The FIFO fills to DEPTH, then `in_rdy` stays 0 in IDLE.
  - `in_rdy` reasserts the cycle after the pop that frees a slot.
- All outputs are driven from registers or from registered state only. There is no combinational path from `in_vld` or `out_rdy` to any output except through state.

## Test plan
Bench core stub: `core_y` = {`core_x`, ~`core_x`} delayed LAT cycles. Parameters: LAT=3, DEPTH=4.

- **Single sample.** Reset, then send 0x5A at edge t.
  - Bytes 0xA5 (`out_hi`=0) at edge t+5, then 0x5A (`out_hi`=1) at edge t+6.
  - `busy` falls after t+6.
  - `in_rdy` is 0 during edges t+1..t+3.
- **Streaming.** `in_vld` and `out_rdy` held 1, samples 0x00..0x0F.
  - Acceptances exactly 4 cycles apart.
  - 32 bytes out in order: 0xFF,0x00, 0xFE,0x01, …
  - fifo_count never exceeds 1.
- **Backpressure / full.** `out_rdy`=0, send 6 samples.
  - The first 5 are accepted: 4 fill the FIFO and 1 is held by the serializer.
  - `in_rdy` then stays 0.
  - Raise `out_rdy`: all 10 bytes appear in order, and the 6th sample is accepted the cycle after the first pop.
- **Wrap-around.** 20 samples with random `out_rdy` (50%).
  - Output order and values match the model exactly.
  - No byte is dropped or duplicated across pointer wrap.
- **Stall mid-pair.** Drop `out_rdy` while in HI for 3 cycles.
  - `out_byte` and `out_hi` stay stable.
  - Low bytes are never repeated.
- **Reset mid-operation.** Assert `rst` for 1 cycle during WAIT, with 2 entries in the FIFO and the serializer in HI.
  - Next cycle: `out_vld`=0, `busy`=0, `core_x`=0, `in_rdy`=1.
  - No old bytes appear afterwards.
